rf_wr_arb: RTL

RF_WR_ARB -- requirements
Module: rf_wr_arb

---
 rtl/rf_wr_arb.sv | 84 ++++++++
 1 files changed

// File: rtl/rf_wr_arb.sv
// Register-file write-port arbiter: two writeback requesters (ALU, load unit)
// share one registered write port, alternating priority after every transfer.
module rf_wr_arb #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            req0_valid,
  input  logic [AW-1:0]   req0_rd,
  input  logic [XLEN-1:0] req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [AW-1:0]   req1_rd,
  input  logic [XLEN-1:0] req1_data,
  output logic            req1_ready,
  output logic            regWrite,
  output logic [AW-1:0]   rd,
  output logic [XLEN-1:0] data,
  output logic [15:0]     wr_count
);

  typedef enum logic {
    PRIO_REQ0 = 1'b0,
    PRIO_REQ1 = 1'b1
  } prio_e;

  prio_e           prio;
  logic            grant0;
  logic            grant1;
  logic            xfer;
  logic [AW-1:0]   sel_rd;
  logic [XLEN-1:0] sel_data;
  logic            wr_issue;

  // A lone requester always wins; the pointer only breaks ties.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst && !stall) begin
      if (req0_valid && (!req1_valid || prio == PRIO_REQ0)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign xfer       = grant0 | grant1;
  assign sel_rd     = grant1 ? req1_rd   : req0_rd;
  assign sel_data   = grant1 ? req1_data : req0_data;
  // Writes to x0 are accepted but never reach the register file.
  assign wr_issue   = xfer && (sel_rd != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio <= PRIO_REQ0;
    end else if (grant0) begin
      prio <= PRIO_REQ1;
    end else if (grant1) begin
      prio <= PRIO_REQ0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regWrite <= 1'b0;
      rd       <= '0;
      data     <= '0;
      wr_count <= '0;
    end else begin
      regWrite <= wr_issue;
      if (wr_issue) begin
        rd       <= sel_rd;
        data     <= sel_data;
        wr_count <= wr_count + 16'd1;
      end
    end
  end

endmodule
